prescaler_ce: RTL and testbench

Multi-channel programmable prescaler that generates single-cycle clock-enable strobes and 50%-duty toggle outputs from one system clock. It supersedes fixed power-of-two ripple division: each channel has a run-time divisor, glitch-free divisor reload, and a global phase-align restart. It feeds baud, sampling and LED-blink logic without creating derived clocks.

---
 rtl/prescaler_ce.sv | 123 ++++++++++++
 tb/tb_prescaler_ce.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prescaler_ce.sv
// Purpose : multi-channel programmable prescaler producing 1-cycle clock-enable strobes and 50%-duty toggles.
// Latency : first strobe is visible the cycle after edge E0+d (E0 = commit/sync edge), then every d enabled cycles.
// Backpr. : none; en_i freezes counting, loads are always captured into the shadow divisor.
//
// Ports:
//   clk_i     system clock, rising edge
//   rstn_i    asynchronous active-low reset
//   en_i      global count enable (counters and toggles hold when low)
//   sync_i    single-cycle phase-aligned restart of every channel
//   load_i    per-channel divisor load request
//   div_i     packed divisors, channel k at [k*WIDTH +: WIDTH]
//   strobe_o  one-cycle pulse per divided period
//   toggle_o  flips on each strobe (period 2*d)
//   pend_o    divisor captured but not yet committed
module prescaler_ce #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      en_i,
    input  logic                      sync_i,
    input  logic [CHANNELS-1:0]       load_i,
    input  logic [CHANNELS*WIDTH-1:0] div_i,
    output logic [CHANNELS-1:0]       strobe_o,
    output logic [CHANNELS-1:0]       toggle_o,
    output logic [CHANNELS-1:0]       pend_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [WIDTH-1:0] shadow_q, active_q, cnt_q;
        logic             pend_q, strobe_q, toggle_q;
        logic [WIDTH-1:0] shadow_d, active_d, cnt_d;
        logic             pend_d, strobe_d, toggle_d;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] staged;
        logic             idle;

        assign div    = div_i[k*WIDTH +: WIDTH];
        // Newest divisor seen by this channel: a same-cycle load beats the shadow copy.
        assign staged = load_i[k] ? div : shadow_q;
        assign idle   = (active_q == '0);

        always_comb begin
            shadow_d = staged;
            active_d = active_q;
            cnt_d    = cnt_q;
            pend_d   = pend_q;
            strobe_d = 1'b0;
            toggle_d = toggle_q;

            if (sync_i) begin
                // Restart all channels in phase, independent of en_i.
                if (pend_q || load_i[k]) begin
                    active_d = staged;
                end
                pend_d   = 1'b0;
                toggle_d = 1'b0;
                if (active_d != '0) begin
                    cnt_d = active_d - ONE;
                end
            end else if (idle) begin
                // An idle channel has no period to finish, so it commits at once.
                // A leftover pending value (loaded on the edge that idled the
                // channel) is treated the same way so it is never stranded.
                if (pend_q || load_i[k]) begin
                    active_d = staged;
                    if (staged != '0) begin
                        cnt_d = staged - ONE;
                    end
                end
                pend_d = 1'b0;
            end else begin
                if (load_i[k]) begin
                    pend_d = 1'b1;
                end
                if (en_i) begin
                    if (cnt_q == '0) begin
                        strobe_d = 1'b1;
                        toggle_d = ~toggle_q;
                        // Reload only at terminal count so no short/long period appears.
                        // A load arriving on this same edge stays pending for the next one.
                        if (pend_q) begin
                            active_d = shadow_q;
                            pend_d   = load_i[k];
                        end
                        // Committing 0 idles the channel; cnt is never loaded with 0-1.
                        if (active_d != '0) begin
                            cnt_d = active_d - ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                shadow_q <= '0;
                active_q <= '0;
                cnt_q    <= '0;
                pend_q   <= 1'b0;
                strobe_q <= 1'b0;
                toggle_q <= 1'b0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
                cnt_q    <= cnt_d;
                pend_q   <= pend_d;
                strobe_q <= strobe_d;
                toggle_q <= toggle_d;
            end
        end

        assign strobe_o[k] = strobe_q;
        assign toggle_o[k] = toggle_q;
        assign pend_o[k]   = pend_q;
    end

endmodule

// File: tb/tb_prescaler_ce.sv
module tb_prescaler_ce;

    localparam int CH = 4;
    localparam int W  = 16;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic            en_i;
    logic            sync_i;
    logic [CH-1:0]   load_i;
    logic [CH*W-1:0] div_i;
    logic [CH-1:0]   strobe_o;
    logic [CH-1:0]   toggle_o;
    logic [CH-1:0]   pend_o;

    prescaler_ce #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en_i     (en_i),
        .sync_i   (sync_i),
        .load_i   (load_i),
        .div_i    (div_i),
        .strobe_o (strobe_o),
        .toggle_o (toggle_o),
        .pend_o   (pend_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [CH-1:0] s;
        logic [CH-1:0] t;
        logic [CH-1:0] p;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Periodic-channel model: counts enabled edges up since the last commit.
    int            md[CH];
    int            mm[CH];
    logic [CH-1:0] ms;
    logic [CH-1:0] mt;

    function automatic void mdl_clear();
        for (int k = 0; k < CH; k++) begin
            md[k] = 0;
            mm[k] = 0;
        end
        ms = '0;
        mt = '0;
    endfunction

    function automatic void mdl_commit(int k, int d);
        md[k] = d;
        mm[k] = 0;
    endfunction

    function automatic void mdl_edge(logic en);
        for (int k = 0; k < CH; k++) begin
            ms[k] = 1'b0;
            if (en && md[k] != 0) begin
                mm[k]++;
                if (mm[k] == md[k]) begin
                    ms[k] = 1'b1;
                    mt[k] = ~mt[k];
                    mm[k] = 0;
                end
            end
        end
    endfunction

    function automatic void mdl_sync();
        for (int k = 0; k < CH; k++) mm[k] = 0;
        ms = '0;
        mt = '0;
    endfunction

    function automatic void push_mdl(logic [CH-1:0] p);
        exp_t e;
        e.s = ms;
        e.t = mt;
        e.p = p;
        sb.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_div(int k, int d);
        div_i[k*W +: W] = W'(d);
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        en_i   = 1'b0;
        sync_i = 1'b0;
        load_i = '0;
        div_i  = '0;
        step();
        step();
        rstn_i = 1'b1;
        step();
        mdl_clear();
    endtask

    task automatic test_reset();
        exp_t e;
        rstn_i = 1'b0;
        en_i   = 1'b1;
        sync_i = 1'b0;
        load_i = '1;
        div_i  = {CH{16'd1}};
        #2;
        for (int n = 0; n < 4; n++) begin
            sb.push_back('0);
            if (n > 0) step();
            e = sb.pop_front();
            n_checks++;
            if ({strobe_o, toggle_o, pend_o} !== e) begin
                n_fail++;
                $display("FAIL reset n=%0d: got s=%b t=%b p=%b, want s=%b t=%b p=%b",
                         n, strobe_o, toggle_o, pend_o, e.s, e.t, e.p);
            end
        end
        do_reset();
    endtask

    task automatic test_basic();
        exp_t e;
        do_reset();
        en_i = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            load_i = (n == 0) ? 4'b0001 : 4'b0000;
            set_div(0, 4);
            mdl_edge(en_i);
            if (n == 0) mdl_commit(0, 4);
            push_mdl('0);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({strobe_o, toggle_o, pend_o} !== e) begin
                n_fail++;
                $display("FAIL basic_d4 n=%0d: got s=%b t=%b p=%b, want s=%b t=%b p=%b",
                         n, strobe_o, toggle_o, pend_o, e.s, e.t, e.p);
            end
        end
    endtask

    // ch1 d=3, loads 4 then 5 mid-period: last value wins, switch at the next strobe.
    task automatic test_reload_midperiod();
        exp_t e;
        logic tog = 1'b0;
        do_reset();
        en_i = 1'b1;
        for (int n = 0; n <= 22; n++) begin
            load_i = (n == 0 || n == 4 || n == 5) ? 4'b0010 : 4'b0000;
            set_div(1, (n == 0) ? 3 : (n == 4) ? 4 : 5);
            e = '0;
            e.s[1] = (n == 3) || (n >= 6 && (n - 6) % 5 == 0);
            tog    = tog ^ e.s[1];
            e.t[1] = tog;
            e.p[1] = (n == 4) || (n == 5);
            sb.push_back(e);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({strobe_o, toggle_o, pend_o} !== e) begin
                n_fail++;
                $display("FAIL reload_mid n=%0d: got s=%b t=%b p=%b, want s=%b t=%b p=%b",
                         n, strobe_o, toggle_o, pend_o, e.s, e.t, e.p);
            end
        end
    endtask

    // d=2,3,6 running, then sync (with a same-cycle load of ch3=4) realigns all phases.
    task automatic test_sync_align();
        exp_t e;
        do_reset();
        en_i = 1'b1;
        set_div(0, 2);
        set_div(1, 3);
        set_div(2, 6);
        set_div(3, 4);
        for (int n = 0; n <= 16; n++) begin
            load_i = (n == 0) ? 4'b0111 : (n == 3) ? 4'b1000 : 4'b0000;
            sync_i = (n == 3);
            if (n == 3) begin
                mdl_sync();
                mdl_commit(3, 4);
            end else begin
                mdl_edge(en_i);
            end
            if (n == 0) begin
                mdl_commit(0, 2);
                mdl_commit(1, 3);
                mdl_commit(2, 6);
            end
            push_mdl('0);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({strobe_o, toggle_o, pend_o} !== e) begin
                n_fail++;
                $display("FAIL sync_align n=%0d: got s=%b t=%b p=%b, want s=%b t=%b p=%b",
                         n, strobe_o, toggle_o, pend_o, e.s, e.t, e.p);
            end
        end
        sync_i = 1'b0;
    endtask

    // ch3 d=1 and ch0 d=4 with en_i low for 3 edges; ch1 loaded while disabled.
    task automatic test_div1_enable();
        exp_t e;
        do_reset();
        set_div(0, 4);
        set_div(1, 2);
        set_div(3, 1);
        for (int n = 0; n <= 16; n++) begin
            en_i   = !(n >= 6 && n <= 8);
            load_i = (n == 0) ? 4'b1001 : (n == 7) ? 4'b0010 : 4'b0000;
            mdl_edge(en_i);
            if (n == 0) begin
                mdl_commit(0, 4);
                mdl_commit(3, 1);
            end
            if (n == 7) mdl_commit(1, 2);
            push_mdl('0);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({strobe_o, toggle_o, pend_o} !== e) begin
                n_fail++;
                $display("FAIL div1_enable n=%0d: got s=%b t=%b p=%b, want s=%b t=%b p=%b",
                         n, strobe_o, toggle_o, pend_o, e.s, e.t, e.p);
            end
        end
        en_i = 1'b1;
    endtask

    // ch2 d=3, load 0 -> one final strobe then idle with toggle held; reload 2 restarts.
    task automatic test_idle_reload();
        exp_t e;
        logic tog = 1'b0;
        do_reset();
        en_i = 1'b1;
        for (int n = 0; n <= 15; n++) begin
            load_i = (n == 0 || n == 1 || n == 8) ? 4'b0100 : 4'b0000;
            set_div(2, (n == 0) ? 3 : (n == 1) ? 0 : 2);
            e = '0;
            e.s[2] = (n == 3) || (n == 10) || (n == 12) || (n == 14);
            tog    = tog ^ e.s[2];
            e.t[2] = tog;
            e.p[2] = (n == 1) || (n == 2);
            sb.push_back(e);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({strobe_o, toggle_o, pend_o} !== e) begin
                n_fail++;
                $display("FAIL idle_reload n=%0d: got s=%b t=%b p=%b, want s=%b t=%b p=%b",
                         n, strobe_o, toggle_o, pend_o, e.s, e.t, e.p);
            end
        end
    endtask

    // Reset pulled mid-cycle with a load pending: outputs clear without a clock edge.
    task automatic test_reset_midperiod();
        exp_t e;
        do_reset();
        en_i = 1'b1;
        for (int n = 0; n <= 3; n++) begin
            load_i = (n == 0) ? 4'b0011 : (n == 3) ? 4'b0001 : 4'b0000;
            set_div(0, (n == 0) ? 5 : 7);
            set_div(1, 2);
            mdl_edge(en_i);
            if (n == 0) begin
                mdl_commit(0, 5);
                mdl_commit(1, 2);
            end
            push_mdl((n == 3) ? 4'b0001 : 4'b0000);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({strobe_o, toggle_o, pend_o} !== e) begin
                n_fail++;
                $display("FAIL rst_mid_pre n=%0d: got s=%b t=%b p=%b, want s=%b t=%b p=%b",
                         n, strobe_o, toggle_o, pend_o, e.s, e.t, e.p);
            end
        end
        load_i = '0;
        #2;
        rstn_i = 1'b0;
        sb.push_back('0);
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({strobe_o, toggle_o, pend_o} !== e) begin
            n_fail++;
            $display("FAIL rst_mid_async: got s=%b t=%b p=%b, want s=%b t=%b p=%b",
                     strobe_o, toggle_o, pend_o, e.s, e.t, e.p);
        end
        #3;
        rstn_i = 1'b1;
        for (int n = 0; n < 8; n++) begin
            sb.push_back('0);
            step();
            e = sb.pop_front();
            n_checks++;
            if ({strobe_o, toggle_o, pend_o} !== e) begin
                n_fail++;
                $display("FAIL rst_mid_post n=%0d: got s=%b t=%b p=%b, want s=%b t=%b p=%b",
                         n, strobe_o, toggle_o, pend_o, e.s, e.t, e.p);
            end
        end
    endtask

    initial begin
        mdl_clear();
        test_reset();
        test_basic();
        test_reload_midperiod();
        test_sync_align();
        test_div1_enable();
        test_idle_reload();
        test_reset_midperiod();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
